// File: rtl/riscv_lsu.sv
// riscv_lsu -- RISC-V load/store unit between the core pipeline and a
// single-beat memory port.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-low reset
//   core_req_i        core load/store request (held stable while stalled)
//   core_we_i         1 = store, 0 = load
//   core_size_i       RISC-V funct3 (B, H, W, BU, HU)
//   core_addr_i       byte address
//   core_wd_i         right-aligned store data
//   core_rd_o         extended load data, non-zero only on load completion
//   core_stall_o      core must hold PC and instruction
//   lsu_err_o         one-cycle pulse: misaligned, illegal size or timeout
//   mem_req_o         memory request
//   mem_we_o          memory write
//   mem_be_o          byte enables
//   mem_addr_o        byte address (passed through unchanged)
//   mem_wd_o          lane-replicated write data
//   mem_rd_i          memory read word
//   mem_ready_i       memory completes the pending access this cycle
module riscv_lsu #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WCNT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;

  logic        legal;
  logic        req, stall, err, done;
  logic [3:0]  be_raw;
  logic [31:0] wd_raw;
  logic [31:0] rd_ext;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;

  // Access legality: supported funct3 and natural alignment; unsigned
  // variants exist only for loads.
  always_comb begin
    legal = 1'b0;
    case (core_size_i)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~core_addr_i[0];
      3'd2:    legal = (core_addr_i[1:0] == 2'b00);
      3'd4:    legal = ~core_we_i;
      3'd5:    legal = ~core_we_i & ~core_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Lane steering. size[1:0] picks the width (B/BU share 0, H/HU share 1),
  // size[2] marks zero extension. Illegal sizes never reach the bus.
  assign rd_shift = mem_rd_i >> {core_addr_i[1:0], 3'b000};
  assign rd_half  = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    be_raw = 4'b1111;
    wd_raw = core_wd_i;
    rd_ext = mem_rd_i;
    case (core_size_i[1:0])
      2'd0: begin
        be_raw = 4'b0001 << core_addr_i[1:0];
        wd_raw = {4{core_wd_i[7:0]}};
        rd_ext = {{24{rd_shift[7] & ~core_size_i[2]}}, rd_shift[7:0]};
      end
      2'd1: begin
        be_raw = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_raw = {2{core_wd_i[15:0]}};
        rd_ext = {{16{rd_half[15] & ~core_size_i[2]}}, rd_half};
      end
      default: begin
        be_raw = 4'b1111;
        wd_raw = core_wd_i;
        rd_ext = mem_rd_i;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    req      = 1'b0;
    stall    = 1'b0;
    err      = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (core_req_i) begin
          if (legal) begin
            req      = 1'b1;
            stall    = 1'b1;
            state_nx = BUSY;
            wcnt_nx  = '0;
          end else begin
            err = 1'b1;
          end
        end
      end
      BUSY: begin
        // A dropped request is a core abort: leave quietly, ignore ready.
        if (!core_req_i) begin
          state_nx = IDLE;
        end else begin
          req = 1'b1;
          if (mem_ready_i) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else if (wcnt == WCNT_LAST) begin
            err      = 1'b1;
            state_nx = IDLE;
          end else begin
            stall   = 1'b1;
            wcnt_nx = wcnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_i) begin
      req   = 1'b0;
      stall = 1'b0;
      err   = 1'b0;
      done  = 1'b0;
    end
  end

  assign mem_req_o    = req;
  assign mem_we_o     = core_we_i & req;
  assign mem_addr_o   = core_addr_i;
  assign mem_be_o     = req ? be_raw : '0;
  assign mem_wd_o     = req ? wd_raw : '0;
  assign core_stall_o = stall;
  assign lsu_err_o    = err;
  assign core_rd_o    = (done && !core_we_i) ? rd_ext : '0;

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL provide parameter: MAX_WAIT, 16, number of BUSY cycles without mem_ready_i before timeout abort (legal range 2..255).
REQ-002 SHALL provide ports, one per line, in this order:
  clk_i  in  1  single clock; all state updates on rising edge
  rst_i  in  1  reset, synchronous, active-low
  core_req_i  in  1  core requests load/store this cycle
  core_we_i  in  1  1 = store, 0 = load
  core_size_i  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
  core_addr_i  in  32  byte address
  core_wd_i  in  32  store data, right-aligned
  core_rd_o  out  32  extended load data
  core_stall_o  out  1  core must hold PC and instruction
  lsu_err_o  out  1  one-cycle pulse: misaligned, illegal size or timeout
  mem_req_o  out  1  memory request
  mem_we_o  out  1  memory write
  mem_be_o  out  4  byte enables
  mem_addr_o  out  32  memory address
  mem_wd_o  out  32  lane-replicated write data
  mem_rd_i  in  32  memory read word
  mem_ready_i  in  1  memory completes the pending access this cycle

Function
REQ-003 SHALL implement FSM states IDLE and BUSY plus wait counter wcnt of $clog2(MAX_WAIT) bits.
REQ-004 SHALL classify access legal iff size in {0,1,2,4,5} (stores: {0,1,2}) and aligned: H/HU addr[0]=0, W addr[1:0]=0.
REQ-005 IDLE, core_req_i=1, legal: mem_req_o=1, core_stall_o=1, next state BUSY, wcnt<=0.
REQ-006 IDLE, core_req_i=1, illegal: mem_req_o=0, core_stall_o=0, lsu_err_o=1 same cycle, remain IDLE.
REQ-007 IDLE, core_req_i=0: mem_req_o=0, core_stall_o=0, lsu_err_o=0.
REQ-008 BUSY: mem_req_o=1 with mem_addr_o/mem_we_o/mem_be_o/mem_wd_o driven from current core inputs (core holds them stable under stall).
REQ-009 BUSY, mem_ready_i=1: core_stall_o=0, core_rd_o valid (loads) same cycle, next state IDLE; minimum access latency 2 cycles (request + completion).
REQ-010 BUSY, mem_ready_i=0, wcnt<MAX_WAIT-1: core_stall_o=1, wcnt increments.
REQ-011 BUSY, mem_ready_i=0, wcnt=MAX_WAIT-1: timeout -- core_stall_o=0, lsu_err_o=1, core_rd_o=0, mem_req_o=1 this cycle, next IDLE.
REQ-012 BUSY, core_req_i=0 (core trap/abort): mem_req_o=0, core_stall_o=0, no error, next IDLE; mem_ready_i ignored.
REQ-013 mem_ready_i in IDLE SHALL be ignored.
REQ-014 mem_addr_o SHALL equal core_addr_i (full byte address); mem_we_o=core_we_i & mem_req_o.
REQ-015 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU addr[1]?4'b1100:4'b0011; W 4'b1111; applied to loads and stores.
REQ-016 Store data: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
REQ-017 Load data: byte/half selected by addr[1:0]/addr[1] from mem_rd_i; B/H sign-extended, BU/HU zero-extended, W unchanged; core_rd_o=0 when no completion.
REQ-018 lsu_err_o SHALL never assert for two consecutive cycles from one access.

Reset
REQ-019 rst_i=0 at a clock edge SHALL force state IDLE, wcnt=0, including mid-BUSY.
REQ-020 While rst_i=0: mem_req_o=0, core_stall_o=0, lsu_err_o=0, core_rd_o=0, mem_be_o=0, mem_wd_o=0.
REQ-021 First cycle after rst_i rises SHALL behave as IDLE.

Verification
REQ-022 LB addr 0x103, mem_rd_i 0x80FF_1234, ready in 2nd cycle -> stall 1,0; core_rd_o 0xFFFF_FF80; be 4'b1000.
REQ-023 SH addr 0x102, wd 0x0000_ABCD -> mem_be_o 4'b1100, mem_wd_o 0xABCD_ABCD, mem_we_o=1, stall released on ready.
REQ-024 LW addr 0x101 -> mem_req_o=0, lsu_err_o=1, stall=0 same cycle, state stays IDLE.
REQ-025 LHU addr 0x100, mem_ready_i held 0 -> stall high for MAX_WAIT cycles after request cycle... exactly: timeout at wcnt=15 (17th cycle incl. request), lsu_err_o pulse, core_rd_o=0.
REQ-026 rst_i=0 during BUSY then released, core_req_i=0 -> all outputs 0; next legal LW completes normally with ready after 3 wait cycles, core_rd_o=mem_rd_i.
REQ-027 core_req_i drops in BUSY with mem_ready_i=1 -> no completion, lsu_err_o=0, mem_req_o=0, returns IDLE.
